// File: rtl/interval_timer.sv
// Programmable interval timer: three interval registers, a 1 s prescaler and a
// RUN/IDLE countdown that emits a one-cycle expired pulse for the downstream FSM.
module interval_timer #(
  parameter int unsigned       TICKS_PER_SEC = 1000,
  parameter int unsigned       CNT_W         = 4,
  parameter logic [CNT_W-1:0] DEF_BASE      = CNT_W'(6),
  parameter logic [CNT_W-1:0] DEF_EXT       = CNT_W'(3),
  parameter logic [CNT_W-1:0] DEF_YEL       = CNT_W'(2)
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic             start_timer,
  input  logic [1:0]       interval_address,
  input  logic             prg_sync_in,
  input  logic [1:0]       time_param_sel,
  input  logic [CNT_W-1:0] time_value,
  output logic             expired,
  output logic [CNT_W-1:0] time_left,
  output logic             running
);

  localparam int unsigned     PS_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] time_left_q, time_left_d;
  logic [PS_W-1:0]  prescaler_q, prescaler_d;
  logic             expired_q,   expired_d;
  logic [CNT_W-1:0] base_q,      base_d;
  logic [CNT_W-1:0] ext_q,       ext_d;
  logic [CNT_W-1:0] yel_q,       yel_d;

  logic [CNT_W-1:0] wr_val;
  logic [CNT_W-1:0] load_val;
  logic             tick;

  // Interval register file. The load mux reads the *_d values so that a write
  // and a start on the same edge hand the freshly written value to the countdown.
  always_comb begin
    // NOTE: every variable assigned here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    base_d = base_q;
    ext_d  = ext_q;
    yel_d  = yel_q;
    wr_val = (time_value == '0) ? CNT_W'(1) : time_value;

    if (prg_sync_in) begin
      case (time_param_sel)
        2'b00:   base_d = wr_val;
        2'b01:   ext_d  = wr_val;
        2'b10:   yel_d  = wr_val;
        default: ;
      endcase
    end

    case (interval_address)
      2'b01:   load_val = ext_d;
      2'b10:   load_val = yel_d;
      default: load_val = base_d;
    endcase
  end

  assign tick = (prescaler_q == PS_LAST);

  // Countdown: start_timer overrides everything, including a coincident final tick.
  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    prescaler_d = prescaler_q;
    expired_d   = 1'b0;

    if (start_timer) begin
      time_left_d = load_val;
      prescaler_d = '0;
      state_d     = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            prescaler_d = '0;
            if (time_left_q > CNT_W'(1)) begin
              time_left_d = time_left_q - CNT_W'(1);
            end else begin
              time_left_d = '0;
              state_d     = IDLE;
              expired_d   = 1'b1;
            end
          end else begin
            prescaler_d = prescaler_q + PS_W'(1);
          end
        end
        default: begin
          time_left_d = '0;
          prescaler_d = '0;
        end
      endcase
    end
  end

  // Reset leaves the BASE interval already loaded and running, so the light
  // sequence starts without any strobe from the FSM.
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      // NOTE: the interval values are a handful of named flops, not a memory
      // array, so resetting them to their defaults costs nothing special.
      base_q      <= DEF_BASE;
      ext_q       <= DEF_EXT;
      yel_q       <= DEF_YEL;
      state_q     <= RUN;
      time_left_q <= DEF_BASE;
      prescaler_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, independent of statement order.
      base_q      <= base_d;
      ext_q       <= ext_d;
      yel_q       <= yel_d;
      state_q     <= state_d;
      time_left_q <= time_left_d;
      prescaler_q <= prescaler_d;
      expired_q   <= expired_d;
    end
  end

  assign expired   = expired_q;
  assign time_left = time_left_q;
  assign running   = (state_q == RUN);

endmodule
